fetch_controller: RTL and testbench

- Sequences instruction fetch: owns the architectural fetch PC, issues word reads on the memory interface, and waits out variable memory latency.
- Buffers returned instructions in a small FIFO toward decode, using a valid/ready handshake.
- Handles branch/jump redirects, including a read already in flight when the redirect arrives.
- Sits between the core's execute/redirect logic and the instruction memory port; replaces direct wiring of the combinational fetch path.

---
 rtl/fetch_controller_if.sv | 12 +
 rtl/fetch_controller.sv | 137 +++++++++++++
 tb/tb_fetch_controller.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_controller_if.sv
// Instruction-memory read port: the fetch controller is the master, the memory the slave.
interface fetch_controller_if;
   logic        enable;
   logic        state;
   logic [31:0] address;
   logic [3:0]  frame_mask;
   logic [31:0] data;
   logic        done;

   modport master (output enable, state, address, frame_mask, input data, done);
   modport slave  (input enable, state, address, frame_mask, output data, done);
endinterface

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the fetch PC, issues one word read at a time and
// buffers returned instructions in a small FIFO toward decode, with redirect handling.
module fetch_controller #(
   parameter logic [31:0] RESET_ADDRESS = 32'h0000_0000,
   parameter int unsigned BUFFER_DEPTH  = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               redirect_valid,
   input  logic [31:0]        redirect_address,
   output logic               instruction_valid,
   output logic [31:0]        instruction,
   output logic [31:0]        instruction_pc,
   input  logic               instruction_ready,
   fetch_controller_if.master memory_interface,
   output logic               fetch_misaligned,
   output logic               busy
);
   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] REQUEST = 3'd1;
   localparam logic [2:0] WAIT    = 3'd2;
   localparam logic [2:0] DISCARD = 3'd3;
   localparam logic [2:0] HOLD    = 3'd4;
   localparam logic [2:0] HALT    = 3'd5;

   localparam logic       MEM_READ  = 1'b0;
   localparam logic [2:0] DEPTH     = 3'(BUFFER_DEPTH);
   localparam logic [1:0] LAST_SLOT = 2'(BUFFER_DEPTH - 1);

   logic [2:0]  fetch_state, state_next;
   logic [31:0] pc;
   logic [31:2] issue_word;
   logic [2:0]  count, count_next;
   logic [1:0]  rd_ptr, wr_ptr;
   logic        halt_pending;
   logic [31:0] slot_data [4];
   logic [31:0] slot_pc   [4];
   logic        push, pop, credit, target_misaligned, enable;

   function automatic logic [1:0] next_slot(input logic [1:0] slot);
      return (slot == LAST_SLOT) ? 2'd0 : slot + 2'd1;
   endfunction

   assign target_misaligned = redirect_address[1:0] != 2'b00;
   assign instruction_valid = count != 3'd0;
   assign push   = (fetch_state == WAIT) && memory_interface.done && !redirect_valid;
   assign pop    = instruction_valid && instruction_ready && !redirect_valid;
   assign credit = count_next < DEPTH;

   always_comb begin
      count_next = count;
      if (redirect_valid)
         count_next = 3'd0;
      else if (push && !pop)
         count_next = count + 3'd1;
      else if (pop && !push)
         count_next = count - 3'd1;
   end

   // A redirect while REQUEST is on the bus still lets that read run, so it is discarded.
   always_comb begin
      state_next = fetch_state;
      if (redirect_valid) begin
         case (fetch_state)
            REQUEST:       state_next = DISCARD;
            WAIT, DISCARD: state_next = memory_interface.done ?
                                        (target_misaligned ? HALT : REQUEST) : DISCARD;
            default:       state_next = target_misaligned ? HALT : REQUEST;
         endcase
      end else begin
         case (fetch_state)
            IDLE:    state_next = REQUEST;
            REQUEST: state_next = WAIT;
            WAIT:    if (memory_interface.done) state_next = credit ? REQUEST : HOLD;
            DISCARD: if (memory_interface.done) state_next = halt_pending ? HALT : REQUEST;
            HOLD:    if (credit) state_next = REQUEST;
            default: state_next = fetch_state;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_state      <= IDLE;
         pc               <= RESET_ADDRESS;
         issue_word       <= '0;
         count            <= 3'd0;
         rd_ptr           <= 2'd0;
         wr_ptr           <= 2'd0;
         halt_pending     <= 1'b0;
         fetch_misaligned <= 1'b0;
      end else begin
         fetch_state <= state_next;
         count       <= count_next;
         if (fetch_state == REQUEST)
            issue_word <= pc[31:2];
         if (redirect_valid) begin
            pc               <= redirect_address;
            fetch_misaligned <= target_misaligned;
            halt_pending     <= target_misaligned;
            rd_ptr           <= 2'd0;
            wr_ptr           <= 2'd0;
         end else begin
            if (push) begin
               pc     <= pc + 32'd4;
               wr_ptr <= next_slot(wr_ptr);
            end
            if (pop)
               rd_ptr <= next_slot(rd_ptr);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         slot_data[wr_ptr] <= memory_interface.data;
         slot_pc[wr_ptr]   <= pc;
      end
   end

   assign busy   = (fetch_state == WAIT) || (fetch_state == DISCARD);
   assign enable = (fetch_state == REQUEST) || busy;

   always_comb begin
      memory_interface.address = 32'd0;
      if (fetch_state == REQUEST)
         memory_interface.address = {pc[31:2], 2'b00};
      else if (busy)
         memory_interface.address = {issue_word, 2'b00};
   end

   assign memory_interface.enable     = enable;
   assign memory_interface.state      = MEM_READ;
   assign memory_interface.frame_mask = enable ? 4'b1111 : 4'b0000;
   assign instruction    = instruction_valid ? slot_data[rd_ptr] : 32'd0;
   assign instruction_pc = instruction_valid ? slot_pc[rd_ptr]   : 32'd0;
endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: transaction-level reference model, directed
// scenarios with literal expectations, then randomized traffic.
module tb_fetch_controller;
  localparam logic [31:0] RESET_ADDR = 32'h0;
  localparam int          DEPTH      = 2;

  logic        clk = 1'b0;
  logic        reset, redirect_valid, instruction_ready;
  logic [31:0] redirect_address;
  logic        instruction_valid, fetch_misaligned, busy;
  logic [31:0] instruction, instruction_pc;
  logic        w_valid, w_misaligned, w_busy;
  logic [31:0] w_instruction, w_pc;

  fetch_controller_if mif();
  fetch_controller_if wif();

  always #5 clk = ~clk;

  fetch_controller #(.RESET_ADDRESS(RESET_ADDR), .BUFFER_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_address(redirect_address),
    .instruction_valid(instruction_valid), .instruction(instruction),
    .instruction_pc(instruction_pc), .instruction_ready(instruction_ready),
    .memory_interface(mif), .fetch_misaligned(fetch_misaligned), .busy(busy));

  fetch_controller #(.RESET_ADDRESS(32'hFFFF_FFFC), .BUFFER_DEPTH(2)) u_wrap (
    .clk(clk), .reset(reset),
    .redirect_valid(1'b0), .redirect_address(32'h0),
    .instruction_valid(w_valid), .instruction(w_instruction),
    .instruction_pc(w_pc), .instruction_ready(1'b1),
    .memory_interface(wif), .fetch_misaligned(w_misaligned), .busy(w_busy));

  // zero-wait memory for the wrap instance, returning the address as data
  assign wif.done = w_busy;
  assign wif.data = wif.address;

  int n_checks = 0, n_errors = 0, cyc = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(string name, int limit);
    n_checks++;
    n_errors++;
    $display("FAIL %s: no event within %0d cycles", name, limit);
  endtask

  // ---------------- reference model (transaction level) ----------------
  bit          m_fresh, m_issue, m_inflight, m_drop, m_halt_after, m_halted, m_flag;
  logic [31:0] m_pc, m_req;
  logic [63:0] m_q[$];

  task automatic model_reset();
    m_fresh = 1; m_issue = 0; m_inflight = 0; m_drop = 0;
    m_halt_after = 0; m_halted = 0; m_flag = 0;
    m_pc = RESET_ADDR; m_req = 0; m_q.delete();
  endtask

  task automatic model_step(bit redir, logic [31:0] tgt, bit rdy, bit dn, logic [31:0] dat);
    bit mis;
    logic [31:0] old_pc;
    mis = (tgt[1:0] != 2'b00);
    old_pc = m_pc;
    if (redir) begin
      m_q.delete(); m_pc = tgt; m_flag = mis;
      if (m_fresh) m_halted = mis;
      else if (m_issue) begin m_inflight = 1; m_req = old_pc; m_drop = 1; m_halt_after = mis; end
      else if (m_inflight && dn) begin m_inflight = 0; m_drop = 0; m_halted = mis; end
      else if (m_inflight) begin m_drop = 1; m_halt_after = mis; end
      else m_halted = mis;
    end else begin
      if (rdy && m_q.size() > 0) void'(m_q.pop_front());
      if (m_issue) begin m_inflight = 1; m_req = m_pc; end
      else if (m_inflight && dn) begin
        m_inflight = 0;
        if (m_drop) m_halted = m_halt_after;
        else begin m_q.push_back({dat, m_pc}); m_pc = m_pc + 32'd4; end
        m_drop = 0;
      end
    end
    m_fresh = 0;
    // credit rule: a new read only when buffered + in-flight stays below depth
    m_issue = !m_halted && !m_inflight && (m_q.size() < DEPTH);
  endtask

  // ---------------- memory model ----------------
  bit          mem_busy, spurious;
  int          mem_cnt, mem_lat;
  logic [31:0] mem_addr, key;
  logic        s_en;
  logic [31:0] s_addr;

  logic [31:0] issued_q[$], popped_pc[$], popped_in[$];
  int          issued_cyc[$];
  logic [31:0] wrap_addr[2];
  int          wrap_n = 0;

  always @(posedge clk) begin
    if (reset !== 1'b1) begin
      mem_busy = 0;
      model_reset();
    end else begin
      model_step(redirect_valid, redirect_address, instruction_ready, mif.done, mif.data);
      if (mem_busy) begin
        if (mem_cnt == 0) mem_busy = 0; else mem_cnt--;
      end else if (s_en) begin
        mem_busy = 1; mem_cnt = mem_lat; mem_addr = s_addr;
      end
      cyc++;
    end
    #1;
    mif.done = (mem_busy && mem_cnt == 0) || (!mem_busy && spurious && $urandom_range(0, 9) == 0);
    mif.data = (mem_busy && mem_cnt == 0) ? (mem_addr ^ key) : $urandom;
  end

  // ---------------- compare process ----------------
  logic        e_en;
  logic [31:0] e_addr;
  logic [63:0] e_head;
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      e_en   = m_issue || m_inflight;
      e_addr = m_issue ? m_pc : (m_inflight ? m_req : 32'h0);
      e_head = (m_q.size() > 0) ? m_q[0] : 64'h0;
      chk("enable", 32'(mif.enable), 32'(e_en));
      chk("address", mif.address, e_addr);
      chk("frame_mask", 32'(mif.frame_mask), e_en ? 32'hF : 32'h0);
      chk("mem_state", 32'(mif.state), 32'h0);
      chk("busy", 32'(busy), 32'(m_inflight));
      chk("instr_valid", 32'(instruction_valid), 32'(m_q.size() > 0));
      chk("misaligned", 32'(fetch_misaligned), 32'(m_flag));
      if (m_q.size() > 0) begin
        chk("instruction", instruction, e_head[63:32]);
        chk("instruction_pc", instruction_pc, e_head[31:0]);
      end
      s_en = mif.enable; s_addr = mif.address;
      if (mif.enable && !busy) begin issued_q.push_back(mif.address); issued_cyc.push_back(cyc); end
      if (instruction_valid && instruction_ready && !redirect_valid) begin
        popped_pc.push_back(instruction_pc); popped_in.push_back(instruction);
      end
      if (wrap_n < 2 && wif.enable && !w_busy) begin wrap_addr[wrap_n] = wif.address; wrap_n++; end
    end else s_en = 0;
  end

  // ---------------- stimulus ----------------
  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clear_logs();
    issued_q.delete(); issued_cyc.delete(); popped_pc.delete(); popped_in.delete();
  endtask

  task automatic do_reset();
    reset = 0; tick(2); clear_logs(); reset = 1;
  endtask

  task automatic redirect_to(logic [31:0] a);
    redirect_valid = 1; redirect_address = a; tick(1); redirect_valid = 0;
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_enable"}, 32'(mif.enable), 32'h0);
    chk({tag, "_address"}, mif.address, 32'h0);
    chk({tag, "_mask"}, 32'(mif.frame_mask), 32'h0);
    chk({tag, "_valid"}, 32'(instruction_valid), 32'h0);
    chk({tag, "_instr"}, instruction, 32'h0);
    chk({tag, "_pc"}, instruction_pc, 32'h0);
    chk({tag, "_misaligned"}, 32'(fetch_misaligned), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
  endtask

  initial begin
    int n0, np, k;
    bit found, ok;
    reset = 0; redirect_valid = 0; redirect_address = 0; instruction_ready = 0;
    mif.done = 0; mif.data = 0; mem_lat = 0; key = 0; spurious = 0;
    #3;
    check_reset_outputs("por");

    // zero-wait memory, data == address, decode always ready
    tick(1); clear_logs(); instruction_ready = 1; reset = 1;
    tick(14);
    chk("p1_issue_count_ge3", 32'(issued_q.size() >= 3), 32'h1);
    if (issued_q.size() >= 3) begin
      chk("p1_addr0", issued_q[0], 32'h0);
      chk("p1_addr1", issued_q[1], 32'h4);
      chk("p1_addr2", issued_q[2], 32'h8);
      chk("p1_spacing", 32'(issued_cyc[2] - issued_cyc[1]), 32'd2);
    end
    chk("p1_pop_count_ge2", 32'(popped_pc.size() >= 2), 32'h1);
    if (popped_pc.size() >= 2) begin
      chk("p1_pair0_instr", popped_in[0], 32'h0);
      chk("p1_pair0_pc", popped_pc[0], 32'h0);
      chk("p1_pair1_instr", popped_in[1], 32'h4);
      chk("p1_pair1_pc", popped_pc[1], 32'h4);
    end

    // 3 wait states, decode stalled: credit limits reads to the buffer depth
    mem_lat = 3; instruction_ready = 0;
    do_reset();
    tick(25);
    chk("p2_issued_depth", 32'(issued_q.size()), 32'd2);
    chk("p2_hold_enable", 32'(mif.enable), 32'h0);
    chk("p2_head_pc", instruction_pc, 32'h0);
    instruction_ready = 1; tick(1); instruction_ready = 0; tick(1);
    chk("p2_one_pop", 32'(popped_pc.size()), 32'd1);
    chk("p2_issued_after_pop", 32'(issued_q.size()), 32'd3);
    chk("p2_addr_after_pop", issued_q.size() >= 3 ? issued_q[2] : 32'hFFFF_FFFF, 32'h8);
    chk("p3_wait_busy", 32'(busy), 32'h1);
    chk("p3_wait_addr", mif.address, 32'h8);

    // redirect during the read at 0x8
    n0 = issued_q.size();
    redirect_to(32'h100);
    chk("p3_flushed", 32'(instruction_valid), 32'h0);
    chk("p3_discard_busy", 32'(busy), 32'h1);
    instruction_ready = 1;
    tick(12);
    chk("p3_next_req", issued_q.size() > n0 ? issued_q[n0] : 32'hFFFF_FFFF, 32'h100);
    found = 0;
    foreach (popped_pc[i]) if (popped_pc[i] == 32'h8) found = 1;
    chk("p3_no_0x8", 32'(found), 32'h0);

    // redirect on the same cycle the read at 0xC completes
    mem_lat = 1; key = 32'h5A5A_0000;
    do_reset();
    ok = 0;
    for (k = 0; k < 60 && !ok; k++) begin
      if (mem_busy && mem_cnt == 0 && mem_addr == 32'hC) ok = 1; else tick(1);
    end
    if (!ok) timeout("p4_done_at_0xC", 60);
    n0 = issued_q.size(); np = popped_pc.size();
    redirect_to(32'h200);
    tick(10);
    chk("p4_next_req", issued_q.size() > n0 ? issued_q[n0] : 32'hFFFF_FFFF, 32'h200);
    chk("p4_first_pc", popped_pc.size() > np ? popped_pc[np] : 32'hFFFF_FFFF, 32'h200);
    chk("p4_first_instr", popped_in.size() > np ? popped_in[np] : 32'hFFFF_FFFF, 32'h200 ^ key);
    found = 0;
    foreach (popped_pc[i]) if (popped_pc[i] == 32'hC || popped_pc[i] == 32'h10) found = 1;
    chk("p4_no_0xC_0x10", 32'(found), 32'h0);

    // misaligned redirect halts fetch until an aligned redirect
    redirect_to(32'h102);
    n0 = issued_q.size();
    chk("p5_flag_set", 32'(fetch_misaligned), 32'h1);
    tick(10);
    chk("p5_no_issue", 32'(issued_q.size()), 32'(n0));
    chk("p5_halt_enable", 32'(mif.enable), 32'h0);
    redirect_to(32'h300);
    chk("p5_flag_clear", 32'(fetch_misaligned), 32'h0);
    tick(6);
    chk("p5_req_0x300", issued_q.size() > n0 ? issued_q[n0] : 32'hFFFF_FFFF, 32'h300);

    // asynchronous reset in the middle of a read
    mem_lat = 5;
    ok = 0;
    for (k = 0; k < 40 && !ok; k++) begin
      if (busy) ok = 1; else tick(1);
    end
    if (!ok) timeout("p6_busy", 40);
    #2; reset = 0; #1;
    check_reset_outputs("async");
    tick(2); clear_logs(); reset = 1;
    tick(6);
    chk("p6_first_req", issued_q.size() > 0 ? issued_q[0] : 32'hFFFF_FFFF, RESET_ADDR);

    // reset-address wrap instance
    chk("wrap_count", 32'(wrap_n), 32'd2);
    chk("wrap_addr0", wrap_addr[0], 32'hFFFF_FFFC);
    chk("wrap_addr1", wrap_addr[1], 32'h0);

    // randomized traffic against the model
    spurious = 1; key = $urandom;
    for (int i = 0; i < 3000; i++) begin
      instruction_ready = ($urandom_range(0, 9) < 7);
      mem_lat = $urandom_range(0, 3);
      redirect_valid = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 4) == 0)
        redirect_address = {$urandom} | 32'h1;
      else
        redirect_address = {$urandom} & 32'hFFFF_FFFC;
      if (i == 1500) reset = 0;
      if (i == 1502) reset = 1;
      tick(1);
    end
    redirect_valid = 0;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required $finish");
    $fatal(1);
  end
endmodule
